// File: rtl/regfile_onehot_wr.sv
// ---------------------------------------------------------------------------
// regfile_onehot_wr
//   NUM_REGS x DATA_WIDTH register file. The write port takes a one-hot
//   word-select vector straight from the upstream write-address decoder.
//   There are two combinational read ports. A write whose select vector
//   has more than one bit set is rejected and raises a sticky error flag.
//   Optionally, a read of the register being written returns the write
//   data in the same cycle (write-to-read bypass).
//
// Ports
//   clock             rising-edge clock for all state
//   ctrl_reset        synchronous active-high reset (registers and flag)
//   ctrl_writeEnable  global write strobe
//   write_onehot      one-hot register select for writes
//   data_writeReg     write data
//   ctrl_readRegA/B   read port selects
//   data_readRegA/B   read port data (0-cycle latency)
//   err_multihot      sticky: a strobed write carried a multi-hot select
// ---------------------------------------------------------------------------
module regfile_onehot_wr #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEnable,
  input  logic [NUM_REGS-1:0]   write_onehot,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  output logic                  err_multihot
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  one_hot;
  logic                  multi_hot;
  logic                  wr_valid;

  always_comb begin
    one_hot   = $onehot(write_onehot);
    multi_hot = (write_onehot != '0) && !one_hot;
    wr_valid  = ctrl_writeEnable && !ctrl_reset && one_hot;
  end

  // Storage and sticky error flag; reset wins over any write in the same cycle.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      err_multihot <= 1'b0;
    end else begin
      if (ctrl_writeEnable && multi_hot) err_multihot <= 1'b1;
      for (int k = 0; k < NUM_REGS; k++) begin
        // Register 0 never takes a write when it is hardwired to zero.
        if (wr_valid && write_onehot[k] && !(ZERO_REG && k == 0))
          regs[k] <= data_writeReg;
      end
    end
  end

  // Read mux: the hardwired zero takes priority over bypass, and bypass over storage.
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [ADDR_WIDTH-1:0] sel,
    input logic                  wr_ok,
    input logic [NUM_REGS-1:0]   wsel,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [DATA_WIDTH-1:0] stored
  );
    if (ZERO_REG && sel == '0)
      return '0;
    else if (BYPASS && wr_ok && wsel[sel])
      return wdata;
    else
      return stored;
  endfunction

  always_comb begin
    data_readRegA = read_port(ctrl_readRegA, wr_valid, write_onehot, data_writeReg,
                              regs[ctrl_readRegA]);
    data_readRegB = read_port(ctrl_readRegB, wr_valid, write_onehot, data_writeReg,
                              regs[ctrl_readRegB]);
  end

endmodule
